// File: rtl/mux_switch_scheduler.sv
// mux_switch_scheduler: 2:1 valid-stream channel selector with manual or dwell-timed
// automatic alternation and a post-switch guard window that blanks the new channel.
module mux_switch_scheduler #(
    parameter int CNT_WIDTH   = 16,
    parameter int GUARD_WIDTH = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   mode_i,
    input  logic                   manual_sel_i,
    input  logic [CNT_WIDTH-1:0]   dwell0_i,
    input  logic [CNT_WIDTH-1:0]   dwell1_i,
    input  logic [GUARD_WIDTH-1:0] guard_i,
    input  logic                   data_valid_i,
    output logic                   sel_o,
    output logic                   blank_o,
    output logic                   switch_o,
    output logic                   state_o
);
    typedef enum logic {RUN = 1'b0, GUARD = 1'b1} state_t;

    localparam logic [CNT_WIDTH:0]   DWELL_ONE = 1;
    localparam logic [GUARD_WIDTH:0] GUARD_ONE = 1;

    state_t                 state, state_n;
    logic [CNT_WIDTH-1:0]   dwell_cnt, dwell_cnt_n, dwell_lim;
    logic [GUARD_WIDTH-1:0] guard_cnt, guard_cnt_n;
    logic                   mode_q, primed, mode_chg;
    logic                   dwell_done, guard_done, do_switch;

    // primed masks the first edge after reset so an idle mode_q never fakes a mode change
    assign mode_chg   = primed && (mode_i != mode_q);
    assign dwell_lim  = sel_o ? dwell1_i : dwell0_i;
    // count+1 >= limit covers both the normal expiry and a live-lowered limit; D=0 acts as 1
    assign dwell_done = ({1'b0, dwell_cnt} + DWELL_ONE) >= {1'b0, dwell_lim};
    assign guard_done = ({1'b0, guard_cnt} + GUARD_ONE) >= {1'b0, guard_i};
    assign do_switch  = (state == RUN) && !mode_chg &&
                        (mode_i ? (data_valid_i && dwell_done) : (manual_sel_i != sel_o));
    assign blank_o    = (state == GUARD);
    assign state_o    = (state == GUARD);

    always_comb begin
        state_n     = state;
        dwell_cnt_n = dwell_cnt;
        guard_cnt_n = guard_cnt;
        if (data_valid_i && dwell_cnt != '1)
            dwell_cnt_n = dwell_cnt + 1'b1;
        if (mode_chg)
            dwell_cnt_n = '0;
        if (do_switch) begin
            dwell_cnt_n = '0;
            guard_cnt_n = '0;
            state_n     = (guard_i != '0) ? GUARD : RUN;
        end else if (state == GUARD && data_valid_i) begin
            state_n     = guard_done ? RUN : GUARD;
            guard_cnt_n = guard_done ? guard_cnt : guard_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= RUN;
            sel_o     <= 1'b0;
            switch_o  <= 1'b0;
            dwell_cnt <= '0;
            guard_cnt <= '0;
            mode_q    <= 1'b0;
            primed    <= 1'b0;
        end else begin
            state     <= state_n;
            sel_o     <= do_switch ? ~sel_o : sel_o;
            switch_o  <= do_switch;
            dwell_cnt <= dwell_cnt_n;
            guard_cnt <= guard_cnt_n;
            mode_q    <= mode_i;
            primed    <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mux_switch_scheduler.sv
// tb_mux_switch_scheduler: directed and random stimulus against a sample-counting
// reference model of the channel scheduler.
module tb_mux_switch_scheduler;
    localparam int CW = 16;
    localparam int GW = 8;

    logic          clk = 0, rst = 1, mode = 0, msel = 0, valid = 0;
    logic [CW-1:0] d0 = 0, d1 = 0;
    logic [GW-1:0] g = 0;
    logic          sel, blank, sw, st;

    int tests = 0, fails = 0;
    int m_sel, m_guard, m_held, m_gseen, m_switch, m_mode, m_primed;
    int pulses;

    mux_switch_scheduler #(.CNT_WIDTH(CW), .GUARD_WIDTH(GW)) dut (
        .clk_i(clk), .rst_i(rst), .mode_i(mode), .manual_sel_i(msel),
        .dwell0_i(d0), .dwell1_i(d1), .guard_i(g), .data_valid_i(valid),
        .sel_o(sel), .blank_o(blank), .switch_o(sw), .state_o(st)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0b expected=%0b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sel = 0; m_guard = 0; m_held = 0; m_gseen = 0;
        m_switch = 0; m_mode = 0; m_primed = 0;
    endtask

    // One clock of the scheduler rules, in terms of samples held and guard samples seen
    task automatic model_edge();
        int  lim;
        bit  flip, mchg;
        lim  = m_sel ? int'(d1) : int'(d0);
        if (lim == 0) lim = 1;
        mchg = m_primed && (int'(mode) != m_mode);
        flip = 0;
        if (!m_guard && !mchg)
            flip = mode ? (valid && (m_held + 1 >= lim)) : (int'(msel) != m_sel);
        m_switch = flip;
        if (flip) begin
            m_sel   = 1 - m_sel;
            m_held  = 0;
            m_gseen = 0;
            m_guard = (g != 0);
        end else begin
            if (valid && m_held < (1 << CW) - 1) m_held++;
            if (mchg) m_held = 0;
            if (m_guard && valid) begin
                if (m_gseen + 1 >= int'(g)) m_guard = 0;
                else m_gseen++;
            end
        end
        m_mode   = mode;
        m_primed = 1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".sel"},    sel,   1'(m_sel));
        chk({tag, ".blank"},  blank, 1'(m_guard));
        chk({tag, ".switch"}, sw,    1'(m_switch));
        chk({tag, ".state"},  st,    1'(m_guard));
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        if (sw) pulses++;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        rst = 1;
        #1;
        model_reset();
        check_all({tag, ".rst"});
        @(posedge clk);
        #1;
        rst = 0;
        pulses = 0;
    endtask

    initial begin
        model_reset();
        pulses = 0;
        #2;
        check_all("por");
        @(posedge clk);
        #1;

        // auto alternation, no guard, valid every cycle: 0,0,0,1,1,0,...
        mode = 1; d0 = 3; d1 = 2; g = 0; valid = 1;
        do_reset("alt");
        for (int i = 0; i < 12; i++) cycle("alt");
        chk("alt.seq_sel_after12", sel, 1'b0);

        // dwell 4, guard 2, valid every other cycle
        d0 = 4; d1 = 4; g = 2;
        do_reset("grd");
        for (int i = 0; i < 40; i++) begin
            valid = i[0];
            cycle("grd");
        end

        // manual toggle with a request deferred through the guard window
        mode = 0; g = 3; valid = 1; msel = 0;
        do_reset("man");
        cycle("man");
        msel = 1;
        cycle("man");
        chk("man.first_switch_sel", sel, 1'b1);
        msel = 0;
        for (int i = 0; i < 10; i++) cycle("man");
        chk("man.pulse_count", 1'(pulses == 2), 1'b1);

        // dwell0 lowered from 10 to 2 once five samples are held
        mode = 1; d0 = 10; d1 = 3; g = 0; valid = 1;
        do_reset("low");
        while (m_held < 5 && m_sel == 0) cycle("low");
        d0 = 2;
        cycle("low");
        chk("low.switch_next_valid", sel, 1'b1);
        for (int i = 0; i < 6; i++) cycle("low");

        // dwell0 = 0 behaves as 1
        d0 = 0; d1 = 2;
        do_reset("zero");
        cycle("zero");
        chk("zero.first_switch", sw, 1'b1);
        for (int i = 0; i < 10; i++) cycle("zero");

        // asynchronous reset in the middle of a guard window
        d0 = 2; d1 = 2; g = 5; valid = 1;
        do_reset("arst");
        for (int i = 0; i < 4; i++) cycle("arst");
        chk("arst.in_guard", st, 1'b1);
        #2;
        rst = 1;
        #1;
        model_reset();
        check_all("arst.immediate");
        @(posedge clk);
        #1;
        rst = 0;
        for (int i = 0; i < 8; i++) cycle("arst.restart");

        // randomized traffic with live parameter changes
        mode = 0; msel = 0;
        do_reset("rnd");
        for (int i = 0; i < 3000; i++) begin
            valid = ($urandom_range(9) < 7);
            if ($urandom_range(19) == 0) mode = ~mode;
            if ($urandom_range(5) == 0) msel = ~msel;
            if ($urandom_range(15) == 0) d0 = CW'($urandom_range(5));
            if ($urandom_range(15) == 0) d1 = CW'($urandom_range(5));
            if ($urandom_range(15) == 0) g = GW'($urandom_range(3));
            if ($urandom_range(499) == 0) begin
                do_reset("rnd");
            end else begin
                cycle("rnd");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mux_switch_scheduler.md
MUX_SWITCH_SCHEDULER -- requirements
Module: mux_switch_scheduler

Interface
REQ-001 Parameter CNT_WIDTH, default 16, width of the dwell counters and dwell inputs.
REQ-002 Parameter GUARD_WIDTH, default 8, width of the guard counter and guard input.
REQ-003 clk_i  input  1  single clock; all logic rising-edge triggered.
REQ-004 rst_i  input  1  asynchronous, active-high reset.
REQ-005 mode_i  input  1  0 = manual select, 1 = automatic alternation.
REQ-006 manual_sel_i  input  1  requested channel in manual mode.
REQ-007 dwell0_i  input  CNT_WIDTH  valid samples held on channel 0 in auto mode.
REQ-008 dwell1_i  input  CNT_WIDTH  valid samples held on channel 1 in auto mode.
REQ-009 guard_i  input  GUARD_WIDTH  valid samples blanked after every switch.
REQ-010 data_valid_i  input  1  sample strobe of the muxed stream, used for all counting.
REQ-011 sel_o  output  1  registered channel select driving the 2:1 valid mux.
REQ-012 blank_o  output  1  registered; high while guard samples are being discarded downstream.
REQ-013 switch_o  output  1  registered one-cycle pulse in the cycle sel_o takes a new value.
REQ-014 state_o  output  1  0 = RUN, 1 = GUARD, for status readback.

Function
REQ-015 The block SHALL implement a two-state FSM (RUN, GUARD) with a dwell counter (CNT_WIDTH) and a guard counter (GUARD_WIDTH).
REQ-016 Counters SHALL advance only in cycles where data_valid_i = 1.
REQ-017 Switch condition in RUN: in manual mode, manual_sel_i != sel_o; in auto mode, data_valid_i = 1 and dwell count >= D-1, where D is dwell0_i or dwell1_i for the current sel_o, and D = 0 is treated as 1.
REQ-018 On a switch condition, the block SHALL invert sel_o on the next clock edge, pulse switch_o in that same registered cycle, and clear the dwell counter.
REQ-019 If guard_i != 0 at the switch, the FSM SHALL enter GUARD, assert blank_o with the new sel_o, and clear the guard counter.
REQ-020 If guard_i == 0 at the switch, the FSM SHALL stay in RUN and blank_o SHALL stay 0.
REQ-021 In GUARD, a data_valid_i with guard count == guard_i-1 (or guard count >= guard_i if guard_i was lowered) SHALL return the FSM to RUN on the next edge and deassert blank_o; otherwise the guard counter increments.
REQ-022 No switch SHALL occur in GUARD: manual requests and expired dwell are deferred and evaluated in the first RUN cycle.
REQ-023 Dwell and guard inputs SHALL be sampled live each cycle: a decrease below the current count triggers the switch or exit at the next data_valid_i.
REQ-024 A mode_i change SHALL reset the dwell counter and is evaluated from the next cycle; it never produces a switch while in GUARD.
REQ-025 Manual-mode switches SHALL NOT require data_valid_i; auto-mode switches SHALL require it.
REQ-026 Dwell counter SHALL saturate at all-ones and never wrap.
REQ-027 Latency from the triggering edge to the sel_o change SHALL be exactly one clock; at most one switch per clock.

Reset
REQ-028 While rst_i = 1 (asynchronous), outputs SHALL be: sel_o = 0, blank_o = 0, switch_o = 0, state_o = RUN, both counters = 0.
REQ-029 After rst_i deasserts, the first switch evaluation SHALL occur on the next rising edge of clk_i.
REQ-030 Reset asserted during GUARD SHALL abort the blanking immediately, with no deferred switch retained.

Verification
REQ-031 Auto mode, dwell0=3, dwell1=2, guard=0, valid every cycle: sel_o sequence 0,0,0,1,1,0,...; switch_o pulses on every change; blank_o stays 0.
REQ-032 Auto mode, dwell0=dwell1=4, guard=2, valid every other cycle: after each switch, blank_o is high for exactly 2 valid samples and state_o = GUARD for the same cycles.
REQ-033 Manual mode, guard=3: toggling manual_sel_i 0->1 gives sel_o = 1 one cycle later; toggling back during GUARD is deferred until the GUARD exit; exactly two switch_o pulses.
REQ-034 Auto mode, dwell0=10, lowered to 2 when count = 5: the switch occurs on the next valid sample.
REQ-035 Auto mode, dwell0=0: behaves as dwell0=1, with a switch on every valid sample while on channel 0.
REQ-036 rst_i asserted mid-GUARD between clock edges: all outputs return to reset values immediately, and the sequence restarts on channel 0 after release.
